// File: rtl/decode.sv
// Instruction decode stage: assembles one/two-byte instructions from fetch, handles flush and HALT.
// Optional feature: define DECODE_ILLEGAL_TRAP_EN to trap reserved opcodes 0x6/0x7 into HALT.
module decode (
  input  logic       clk,
  input  logic       sync_rst,
  input  logic [7:0] pc,
  input  logic [7:0] word,
  input  logic       flush,
  output logic       dec_valid,
  output logic [3:0] dec_op,
  output logic [1:0] dec_rd,
  output logic [1:0] dec_rs,
  output logic [7:0] dec_imm,
  output logic       dec_has_imm,
  output logic [7:0] dec_pc,
  output logic       dec_is_branch,
  output logic       dec_halted,
  output logic       dec_illegal
);

  localparam logic [1:0] ST_OP   = 2'd0;
  localparam logic [1:0] ST_IMM  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [1:0] state_r;
  logic [1:0] state_s;

  // opcode byte of a two-byte instruction, held while waiting for its immediate
  logic [7:0] op_byte_r;
  logic [7:0] op_pc_r;
  logic       latch_s;

  logic       emit_s;
  logic [7:0] emit_byte_s;
  logic [7:0] emit_imm_s;
  logic       emit_has_imm_s;
  logic [7:0] emit_pc_s;
  logic       emit_illegal_s;
  logic       word_reserved_s;

  assign word_reserved_s = (word[7:4] == 4'h6) || (word[7:4] == 4'h7);

  // next-state and emission selection; flush outranks decode in every state
  always_comb begin
    state_s        = state_r;
    latch_s        = 1'b0;
    emit_s         = 1'b0;
    emit_byte_s    = 8'h00;
    emit_imm_s     = 8'h00;
    emit_has_imm_s = 1'b0;
    emit_pc_s      = 8'h00;
    emit_illegal_s = 1'b0;
    case (state_r)
      ST_OP: begin
        if (flush) begin
          state_s = ST_OP;
        end else if (word[7]) begin
          state_s = ST_IMM;
          latch_s = 1'b1;
        end else begin
          emit_s         = 1'b1;
          emit_byte_s    = word;
          emit_pc_s      = pc;
          emit_illegal_s = TRAP_EN && word_reserved_s;
          if ((word == 8'h00) || (TRAP_EN && word_reserved_s)) begin
            state_s = ST_HALT;
          end else begin
            state_s = ST_OP;
          end
        end
      end
      ST_IMM: begin
        if (flush) begin
          state_s = ST_OP;
        end else begin
          emit_s         = 1'b1;
          emit_byte_s    = op_byte_r;
          emit_imm_s     = word;
          emit_has_imm_s = 1'b1;
          emit_pc_s      = op_pc_r;
          state_s        = ST_OP;
        end
      end
      ST_HALT: begin
        if (flush) begin
          state_s = ST_OP;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_OP;
      end
    endcase
  end

  // state, latched opcode and registered outputs; fields hold between emissions
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_r       <= ST_OP;
      op_byte_r     <= 8'h00;
      op_pc_r       <= 8'h00;
      dec_valid     <= 1'b0;
      dec_op        <= 4'h0;
      dec_rd        <= 2'd0;
      dec_rs        <= 2'd0;
      dec_imm       <= 8'h00;
      dec_has_imm   <= 1'b0;
      dec_pc        <= 8'h00;
      dec_is_branch <= 1'b0;
      dec_halted    <= 1'b0;
      dec_illegal   <= 1'b0;
    end else begin
      state_r    <= state_s;
      dec_valid  <= emit_s;
      dec_halted <= (state_s == ST_HALT);
      if (latch_s) begin
        op_byte_r <= word;
        op_pc_r   <= pc;
      end
      if (emit_s) begin
        dec_op        <= emit_byte_s[7:4];
        dec_rd        <= emit_byte_s[3:2];
        dec_rs        <= emit_byte_s[1:0];
        dec_imm       <= emit_imm_s;
        dec_has_imm   <= emit_has_imm_s;
        dec_pc        <= emit_pc_s;
        dec_is_branch <= (emit_byte_s[7:6] == 2'b11);
        dec_illegal   <= emit_illegal_s;
      end
    end
  end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed test-plan cases plus random byte stream vs a behavioural model.
module tb_decode;

`ifdef DECODE_ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       sync_rst;
  logic [7:0] pc;
  logic [7:0] word;
  logic       flush;
  logic       dec_valid;
  logic [3:0] dec_op;
  logic [1:0] dec_rd;
  logic [1:0] dec_rs;
  logic [7:0] dec_imm;
  logic       dec_has_imm;
  logic [7:0] dec_pc;
  logic       dec_is_branch;
  logic       dec_halted;
  logic       dec_illegal;

  decode dut (
    .clk(clk), .sync_rst(sync_rst), .pc(pc), .word(word), .flush(flush),
    .dec_valid(dec_valid), .dec_op(dec_op), .dec_rd(dec_rd), .dec_rs(dec_rs),
    .dec_imm(dec_imm), .dec_has_imm(dec_has_imm), .dec_pc(dec_pc),
    .dec_is_branch(dec_is_branch), .dec_halted(dec_halted), .dec_illegal(dec_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic [7:0] opbyte;
    logic [7:0] imm;
    logic       has_imm;
    logic [7:0] pc;
    logic       halted;
    logic       illegal;
  } exp_t;

  exp_t exp_now;
  exp_t exp_nxt;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  // model state, described as "halted" and "an opcode byte awaiting its immediate"
  bit       m_halted;
  bit       m_pending;
  logic [7:0] m_pend_byte;
  logic [7:0] m_pend_pc;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, expv);
    end
  endtask

  function automatic bit reserved(input logic [7:0] b);
    return (b[7:4] == 4'd6) || (b[7:4] == 4'd7);
  endfunction

  task automatic model_emit(input logic [7:0] b, input logic [7:0] imm, input bit has, input logic [7:0] p);
    exp_nxt.valid   = 1'b1;
    exp_nxt.opbyte  = b;
    exp_nxt.imm     = imm;
    exp_nxt.has_imm = has;
    exp_nxt.pc      = p;
    exp_nxt.illegal = TRAP && reserved(b);
  endtask

  task automatic model(input bit r, input logic [7:0] p, input logic [7:0] w, input bit f);
    exp_nxt = exp_now;
    exp_nxt.valid = 1'b0;
    if (r) begin
      exp_nxt   = '0;
      m_halted  = 1'b0;
      m_pending = 1'b0;
    end else if (m_halted) begin
      if (f) m_halted = 1'b0;
    end else if (f) begin
      m_pending = 1'b0;
    end else if (m_pending) begin
      model_emit(m_pend_byte, w, 1'b1, m_pend_pc);
      m_pending = 1'b0;
    end else if (w >= 8'h80) begin
      m_pending   = 1'b1;
      m_pend_byte = w;
      m_pend_pc   = p;
    end else begin
      model_emit(w, 8'h00, 1'b0, p);
      if (w == 8'h00 || (TRAP && reserved(w))) m_halted = 1'b1;
    end
    exp_nxt.halted = m_halted;
  endtask

  task automatic step(input bit r, input logic [7:0] p, input logic [7:0] w, input bit f);
    sync_rst = r; pc = p; word = w; flush = f;
    model(r, p, w, f);
    @(posedge clk);
    #1;
    exp_now = exp_nxt;
    @(negedge clk);
  endtask

  // every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", int'(dec_valid), int'(exp_now.valid));
      chk("op", int'(dec_op), int'(exp_now.opbyte[7:4]));
      chk("rd", int'(dec_rd), int'(exp_now.opbyte[3:2]));
      chk("rs", int'(dec_rs), int'(exp_now.opbyte[1:0]));
      chk("imm", int'(dec_imm), int'(exp_now.imm));
      chk("has_imm", int'(dec_has_imm), int'(exp_now.has_imm));
      chk("pc", int'(dec_pc), int'(exp_now.pc));
      chk("is_branch", int'(dec_is_branch), int'(exp_now.opbyte[7:4] >= 4'hC));
      chk("halted", int'(dec_halted), int'(exp_now.halted));
      chk("illegal", int'(dec_illegal), int'(exp_now.illegal));
    end
  end

  initial begin
    logic [7:0] rpc;
    exp_now = '0; exp_nxt = '0;
    m_halted = 1'b0; m_pending = 1'b0; m_pend_byte = 8'h00; m_pend_pc = 8'h00;
    sync_rst = 1'b1; pc = 8'h00; word = 8'h00; flush = 1'b0;
    @(negedge clk);
    step(1'b1, 8'h00, 8'hFF, 1'b0);
    chk_en = 1'b1;
    chk("lit_reset_valid", int'(dec_valid), 0);
    chk("lit_reset_halted", int'(dec_halted), 0);

    // single-byte pair
    step(1'b0, 8'h00, 8'h15, 1'b0);
    chk("lit_15_valid", int'(dec_valid), 1);
    chk("lit_15_fields", int'({dec_op, dec_rd, dec_rs}), 'h15);
    step(1'b0, 8'h01, 8'h2A, 1'b0);
    chk("lit_2A_fields", int'({dec_op, dec_rd, dec_rs}), 'h2A);
    chk("lit_2A_pc", int'(dec_pc), 'h01);
    chk("lit_2A_imm", int'(dec_imm), 'h00);

    // two-byte
    step(1'b0, 8'h10, 8'h94, 1'b0);
    chk("lit_94_nopulse", int'(dec_valid), 0);
    step(1'b0, 8'h11, 8'h5C, 1'b0);
    chk("lit_94_valid", int'(dec_valid), 1);
    chk("lit_94_op", int'(dec_op), 9);
    chk("lit_94_imm", int'(dec_imm), 'h5C);
    chk("lit_94_pc", int'(dec_pc), 'h10);

    // branch with flush in its emit cycle
    step(1'b0, 8'h20, 8'hC0, 1'b0);
    step(1'b0, 8'h21, 8'h40, 1'b0);
    chk("lit_br_is_branch", int'(dec_is_branch), 1);
    step(1'b0, 8'h22, 8'h33, 1'b1);
    chk("lit_br_shadow", int'(dec_valid), 0);
    step(1'b0, 8'h40, 8'h15, 1'b0);
    chk("lit_br_target_pc", int'(dec_pc), 'h40);

    // HALT and flush exit
    step(1'b0, 8'h50, 8'h00, 1'b0);
    chk("lit_halt_valid", int'(dec_valid), 1);
    chk("lit_halt_flag", int'(dec_halted), 1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h51 + 8'(i), 8'h15, 1'b0);
      chk("lit_halt_quiet", int'(dec_valid), 0);
    end
    step(1'b0, 8'h54, 8'h15, 1'b1);
    chk("lit_halt_exit", int'(dec_halted), 0);
    step(1'b0, 8'h60, 8'h15, 1'b0);
    chk("lit_resume_op", int'(dec_valid && dec_op == 4'd1), 1);

    // pc wrap
    step(1'b0, 8'hFF, 8'h80, 1'b0);
    step(1'b0, 8'h00, 8'h7E, 1'b0);
    chk("lit_wrap_pc", int'(dec_pc), 'hFF);
    chk("lit_wrap_imm", int'(dec_imm), 'h7E);

    // reset while waiting for an immediate
    step(1'b0, 8'h30, 8'h94, 1'b0);
    step(1'b1, 8'h31, 8'h5C, 1'b0);
    chk("lit_rst_imm_op", int'(dec_op), 0);
    chk("lit_rst_imm_pc", int'(dec_pc), 0);
    step(1'b0, 8'h00, 8'h5C, 1'b0);
    chk("lit_rst_imm_restart", int'(dec_has_imm), 0);

    // reserved opcode
    step(1'b0, 8'h01, 8'h70, 1'b0);
    chk("lit_70_op", int'(dec_op), 7);
    chk("lit_70_illegal", int'(dec_illegal), int'(TRAP));
    chk("lit_70_halted", int'(dec_halted), int'(TRAP));
    step(1'b0, 8'h02, 8'h15, 1'b0);
    chk("lit_70_next", int'(dec_valid), int'(!TRAP));
    step(1'b0, 8'h03, 8'h15, 1'b1);

    // random stream
    rpc = 8'h00;
    for (int i = 0; i < 2000; i++) begin
      logic [7:0] w;
      bit f, r;
      w = 8'($urandom);
      if ($urandom_range(0, 9) == 0) w = 8'h00;
      f = ($urandom_range(0, 9) == 0);
      r = ($urandom_range(0, 49) == 0);
      step(r, rpc, w, f);
      rpc = f ? 8'($urandom) : rpc + 8'd1;
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/decode.md
# decode

Instruction decode stage for the 8-bit core, directly downstream of fetch. It consumes one instruction byte and its PC every clock and assembles one- or two-byte instructions. It emits one registered decoded instruction per completed instruction to execute. It also handles pipeline flush on branch redirect and the HALT state.

## Interface
- Parameters: none.
- `clk` in 1: core clock, all state updates on rising edge.
- `sync_rst` in 1: synchronous, active-high reset.
- `pc` in 8: address of `word` this cycle, from fetch.
- `word` in 8: instruction byte at `pc`, from fetch.
- `flush` in 1: execute redirected fetch this cycle; asserted in the same cycle as fetch's `branch_wr_en`.
- `dec_valid` out 1: one-cycle pulse; decoded instruction fields valid.
- `dec_op` out 4: opcode, byte0[7:4].
- `dec_rd` out 2: destination register, byte0[3:2].
- `dec_rs` out 2: source register, byte0[1:0].
- `dec_imm` out 8: immediate (byte1); 0x00 for single-byte instructions.
- `dec_has_imm` out 1: instruction was two-byte.
- `dec_pc` out 8: PC of the opcode byte.
- `dec_is_branch` out 1: `dec_op` in 0xC–0xF.
- `dec_halted` out 1: decoder is in HALT.
- `dec_illegal` out 1: reserved opcode decoded (see Configuration).

## Operation
- Encoding:
  - op[3]=1 means a two-byte instruction; the immediate byte follows.
  - op 0x6 and 0x7 are reserved and single-byte.
  - Byte 0x00 (op 0, rd 0, rs 0) is HALT.
- No backpressure. Fetch advances every cycle, so decode consumes `word` every cycle unless in HALT.
- FSM states: OP, IMM, HALT.
- OP:
  - flush: discard `word`, stay OP.
  - Otherwise latch fields and `pc`.
  - op[3]=0: emit next cycle. If byte is 0x00, emit, then go to HALT.
  - op[3]=1: go to IMM, emit nothing.
- IMM:
  - flush: drop the latched opcode, go to OP, emit nothing.
  - Otherwise emit with `dec_imm`=`word`, `dec_has_imm`=1, `dec_pc`=latched opcode PC. Go to OP.
- HALT:
  - `word` ignored, no emissions, `dec_halted`=1.
  - flush: go to OP. Flush is the only exit besides reset.
- Output fields hold their last emitted values while `dec_valid`=0.
- PC wrap: an opcode at 0xFF with its immediate at 0x00 is legal. `dec_pc`=0xFF.
- Priority, highest first: `sync_rst`, then `flush`, then normal decode.

## Timing
- Reset values:
  - state=OP.
  - `dec_valid`=0, `dec_op`=0, `dec_rd`=0, `dec_rs`=0, `dec_imm`=0x00, `dec_pc`=0x00.
  - `dec_has_imm`=0, `dec_is_branch`=0, `dec_halted`=0, `dec_illegal`=0.
- All outputs are registered; none are combinational from inputs.
- Single-byte instruction: opcode at cycle t gives `dec_valid`=1 at t+1.
- Two-byte instruction: opcode at t, immediate at t+1, gives `dec_valid`=1 at t+2.
- Branch shadow: execute receives a branch at cycle t+1 and asserts `flush` in t+1. The byte presented in t+1 is discarded, and `dec_valid`=0 at t+2. The target byte arrives at t+2.
- HALT: `dec_valid`=1 with `dec_op`=0 at t+1, and `dec_halted`=1 from t+1. After `flush` at cycle s, `dec_halted`=0 at s+1 and decoding resumes with the byte at s+1.
- Reset asserted mid-instruction, in IMM, abandons the partial instruction. Outputs take reset values the next cycle.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined:
  - op 0x6/0x7 emit `dec_valid`=1 with `dec_illegal`=1.
  - Decode then enters HALT (`dec_halted`=1 next cycle), exiting only on flush or reset.
- `DECODE_ILLEGAL_TRAP_EN` undefined:
  - `dec_illegal` is tied 0.
  - op 0x6/0x7 decode as ordinary single-byte instructions, with no HALT entry.

## Test plan
- Reset, then bytes 0x15 at pc 0x00 and 0x2A at pc 0x01 → `dec_valid` at cycles 1 and 2 with (op1,rd1,rs1,pc0x00) and (op2,rd2,rs2,pc0x01), `dec_imm`=0x00.
- Bytes 0x94, 0x5C at pc 0x10/0x11 → one `dec_valid` at t+2: op9, rd1, rs0, imm0x5C, `dec_has_imm`=1, `dec_pc`=0x10; no pulse at t+1.
- Branch 0xC0, 0x40 at pc 0x20/0x21; `flush` in the cycle it is emitted, with wrong-path byte 0x33 → 0x33 never emitted; next target byte decoded normally.
- Byte 0x00 then 0x15 ×3 → one pulse op0, `dec_halted`=1, no further pulses. `flush` then 0x15 → `dec_halted`=0, op1 emitted.
- Opcode 0x80 at pc 0xFF, imm 0x7E at pc 0x00 → `dec_pc`=0xFF, `dec_imm`=0x7E. Separately, `sync_rst` in IMM → all outputs at reset values next cycle.
- Byte 0x70: with `DECODE_ILLEGAL_TRAP_EN`, `dec_illegal`=1 and `dec_halted`=1 next cycle. Without it, op7 is emitted with `dec_illegal`=0 and decoding continues.
